// File: rtl/ram_word_sequencer.sv
// ram_word_sequencer
// Splits 32-bit word loads/stores into two 16-bit accesses on a single
// 256x16 iCE40 block RAM (low half first, then high half) and returns
// one response pulse per request.

module ram_word_sequencer #(
    parameter int ADDR_W          = 7,
    parameter int SKIP_EMPTY_HALF = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,

    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,

    output logic [15:0]       ram_wdata,
    output logic [15:0]       ram_mask,
    output logic [7:0]        ram_waddr,
    output logic              ram_we,
    output logic [7:0]        ram_raddr,
    output logic              ram_re,
    input  logic [15:0]       ram_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_LO  = 3'd1,
        WR_HI  = 3'd2,
        RD_LO  = 3'd3,
        RD_HI  = 3'd4,
        RD_CAP = 3'd5
    } state_t;

    localparam bit SKIP = (SKIP_EMPTY_HALF != 0);

    state_t            state;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        be_reg;
    logic [15:0]       lo_reg;

    assign req_ready = (state == IDLE);

    // Sequencer: latches the request, walks the half accesses and emits the response pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            lo_reg    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        be_reg    <= req_be;
                        if (!req_we) begin
                            state <= RD_LO;
                        end else if (SKIP && (req_be == 4'b0000)) begin
                            rsp_valid <= 1'b1;
                        end else if (SKIP && (req_be[1:0] == 2'b00)) begin
                            state <= WR_HI;
                        end else begin
                            state <= WR_LO;
                        end
                    end
                end
                WR_LO: begin
                    if (SKIP && (be_reg[3:2] == 2'b00)) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                    end else begin
                        state <= WR_HI;
                    end
                end
                WR_HI: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b1;
                end
                RD_LO: begin
                    state <= RD_HI;
                end
                RD_HI: begin
                    lo_reg <= ram_rdata;
                    state  <= RD_CAP;
                end
                RD_CAP: begin
                    rsp_rdata <= {ram_rdata, lo_reg};
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM port decode: strobes and buses come straight from the state so reset kills them at once
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = '0;
        ram_raddr = '0;
        ram_wdata = '0;
        ram_mask  = '0;
        case (state)
            WR_LO: begin
                ram_we    = 1'b1;
                ram_waddr = {addr_reg, 1'b0};
                ram_wdata = wdata_reg[15:0];
                ram_mask  = {{8{~be_reg[1]}}, {8{~be_reg[0]}}};
            end
            WR_HI: begin
                ram_we    = 1'b1;
                ram_waddr = {addr_reg, 1'b1};
                ram_wdata = wdata_reg[31:16];
                ram_mask  = {{8{~be_reg[3]}}, {8{~be_reg[2]}}};
            end
            RD_LO: begin
                ram_re    = 1'b1;
                ram_raddr = {addr_reg, 1'b0};
            end
            RD_HI: begin
                ram_re    = 1'b1;
                ram_raddr = {addr_reg, 1'b1};
            end
            default: begin
            end
        endcase
    end

endmodule
